// File: rtl/encoder_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : encoder_scan_ctrl
// Purpose  : Round-robin scanner for NUM_ENC quadrature encoders with push
//            buttons. Accumulates saturating signed step deltas per encoder.
//            A host read port with read-and-clear semantics shares the state
//            table with the scanner.
// Ports    : clk, reset         - clock, synchronous active-high reset
//            debounced[15:0]    - bit 3i=A, 3i+1=B, 3i+2=button of encoder i
//            host_req/host_idx  - read request and encoder index
//            host_ack           - read data valid, one clock after host_req
//            host_delta/btn/btn_chg/err - entry contents before the clear
//            irq                - any entry has delta!=0, btn_chg or err
// Revision : 1.0 - initial release
// ============================================================================
module encoder_scan_ctrl #(
    parameter int SCAN_DIV = 15,
    parameter int NUM_ENC  = 5,
    parameter int DELTA_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [15:0]        debounced,
    input  logic               host_req,
    input  logic [2:0]         host_idx,
    output logic               host_ack,
    output logic [DELTA_W-1:0] host_delta,
    output logic               host_btn,
    output logic               host_btn_chg,
    output logic               host_err,
    output logic               irq
);

    localparam int                 DIV_W        = (SCAN_DIV > 0) ? $clog2(SCAN_DIV + 1) : 1;
    localparam logic [DIV_W-1:0]   c_DIV_RELOAD = DIV_W'(SCAN_DIV);
    localparam logic [2:0]         c_LAST_IDX   = 3'(NUM_ENC - 1);
    localparam logic [2:0]         c_NUM_ENC    = 3'(NUM_ENC);

    // Quadrature phase position along the forward sequence 00->01->11->10.
    function automatic logic [1:0] phase_pos(input logic [1:0] ab);
        phase_pos = {ab[1], ab[1] ^ ab[0]};
    endfunction

    // Signed add of a -1/0/+1 increment, clamped at the representable limits.
    function automatic logic [DELTA_W-1:0] sat_add(input logic [DELTA_W-1:0] a,
                                                   input logic [1:0]         inc);
        logic [DELTA_W:0] sum;
        sum = {a[DELTA_W-1], a} + {{(DELTA_W-1){inc[1]}}, inc};
        if (sum[DELTA_W] != sum[DELTA_W-1])
            sat_add = sum[DELTA_W] ? {1'b1, {(DELTA_W-1){1'b0}}}
                                   : {1'b0, {(DELTA_W-1){1'b1}}};
        else
            sat_add = sum[DELTA_W-1:0];
    endfunction

    // Per-encoder views of the debounced vector
    logic [1:0] w_ab  [NUM_ENC];
    logic       w_btn [NUM_ENC];

    generate
        for (genvar g = 0; g < NUM_ENC; g++) begin : g_unpack
            assign w_ab[g]  = {debounced[3*g+1], debounced[3*g]};
            assign w_btn[g] = debounced[3*g+2];
        end
    endgenerate

    // State table
    logic [DELTA_W-1:0] delta_q   [NUM_ENC], delta_d   [NUM_ENC];
    logic [1:0]         prev_ab_q [NUM_ENC], prev_ab_d [NUM_ENC];
    logic               prev_btn_q[NUM_ENC], prev_btn_d[NUM_ENC];
    logic               btn_chg_q [NUM_ENC], btn_chg_d [NUM_ENC];
    logic               err_q     [NUM_ENC], err_d     [NUM_ENC];
    logic               valid_q   [NUM_ENC], valid_d   [NUM_ENC];

    logic [DIV_W-1:0]   div_q, div_d;
    logic [2:0]         scan_idx_q, scan_idx_d;

    logic               ack_q, ack_d;
    logic [DELTA_W-1:0] hdelta_q, hdelta_d;
    logic               hbtn_q, hbtn_d;
    logic               hchg_q, hchg_d;
    logic               herr_q, herr_d;
    logic               irq_q, irq_d;

    // Scanner decode for the entry currently being visited
    logic       w_scan_step;
    logic [1:0] w_cur_ab;
    logic       w_cur_btn;
    logic [1:0] w_pos_diff;
    logic [1:0] w_inc;
    logic       w_bad;
    logic       w_host_ok;

    assign w_scan_step = (div_q == '0);
    assign w_cur_ab    = w_ab[scan_idx_q];
    assign w_cur_btn   = w_btn[scan_idx_q];
    assign w_pos_diff  = phase_pos(w_cur_ab) - phase_pos(prev_ab_q[scan_idx_q]);
    assign w_inc       = (w_pos_diff == 2'd1) ? 2'b01 :
                         (w_pos_diff == 2'd3) ? 2'b11 : 2'b00;
    // A two-bit jump has no defined direction: flag it, count nothing.
    assign w_bad       = (w_pos_diff == 2'd2);
    assign w_host_ok   = host_req && (host_idx < c_NUM_ENC);

    always_comb begin
        for (int i = 0; i < NUM_ENC; i++) begin
            delta_d[i]    = delta_q[i];
            prev_ab_d[i]  = prev_ab_q[i];
            prev_btn_d[i] = prev_btn_q[i];
            btn_chg_d[i]  = btn_chg_q[i];
            err_d[i]      = err_q[i];
            valid_d[i]    = valid_q[i];
        end
        div_d      = div_q - 1'b1;
        scan_idx_d = scan_idx_q;

        // Host clear is applied first; a colliding scan step then accumulates
        // on top of the cleared entry so only this step's events remain.
        if (w_host_ok) begin
            delta_d[host_idx]   = '0;
            btn_chg_d[host_idx] = 1'b0;
            err_d[host_idx]     = 1'b0;
        end

        if (w_scan_step) begin
            div_d      = c_DIV_RELOAD;
            scan_idx_d = (scan_idx_q == c_LAST_IDX) ? 3'd0 : scan_idx_q + 3'd1;
            if (!valid_q[scan_idx_q]) begin
                // First visit only captures levels so power-up state never counts.
                valid_d[scan_idx_q] = 1'b1;
            end else begin
                delta_d[scan_idx_q]   = sat_add(delta_d[scan_idx_q], w_inc);
                err_d[scan_idx_q]     = err_d[scan_idx_q] | w_bad;
                btn_chg_d[scan_idx_q] = btn_chg_d[scan_idx_q] |
                                        (w_cur_btn != prev_btn_q[scan_idx_q]);
            end
            prev_ab_d[scan_idx_q]  = w_cur_ab;
            prev_btn_d[scan_idx_q] = w_cur_btn;
        end

        // Read data reflects the entry before any clear or scan this cycle
        ack_d    = host_req;
        hdelta_d = '0;
        hbtn_d   = 1'b0;
        hchg_d   = 1'b0;
        herr_d   = 1'b0;
        if (w_host_ok) begin
            hdelta_d = delta_q[host_idx];
            hbtn_d   = prev_btn_q[host_idx];
            hchg_d   = btn_chg_q[host_idx];
            herr_d   = err_q[host_idx];
        end

        irq_d = 1'b0;
        for (int i = 0; i < NUM_ENC; i++) begin
            irq_d = irq_d | (delta_q[i] != '0) | btn_chg_q[i] | err_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_ENC; i++) begin
                delta_q[i]    <= '0;
                prev_ab_q[i]  <= '0;
                prev_btn_q[i] <= 1'b0;
                btn_chg_q[i]  <= 1'b0;
                err_q[i]      <= 1'b0;
                valid_q[i]    <= 1'b0;
            end
            div_q      <= c_DIV_RELOAD;
            scan_idx_q <= 3'd0;
            ack_q      <= 1'b0;
            hdelta_q   <= '0;
            hbtn_q     <= 1'b0;
            hchg_q     <= 1'b0;
            herr_q     <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_ENC; i++) begin
                delta_q[i]    <= delta_d[i];
                prev_ab_q[i]  <= prev_ab_d[i];
                prev_btn_q[i] <= prev_btn_d[i];
                btn_chg_q[i]  <= btn_chg_d[i];
                err_q[i]      <= err_d[i];
                valid_q[i]    <= valid_d[i];
            end
            div_q      <= div_d;
            scan_idx_q <= scan_idx_d;
            ack_q      <= ack_d;
            hdelta_q   <= hdelta_d;
            hbtn_q     <= hbtn_d;
            hchg_q     <= hchg_d;
            herr_q     <= herr_d;
            irq_q      <= irq_d;
        end
    end

    assign host_ack     = ack_q;
    assign host_delta   = hdelta_q;
    assign host_btn     = hbtn_q;
    assign host_btn_chg = hchg_q;
    assign host_err     = herr_q;
    assign irq          = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_encoder_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_encoder_scan_ctrl
// Purpose  : Directed self-checking bench for encoder_scan_ctrl with default
//            parameters (one scan step every 16 clocks, full scan 80 clocks).
// Revision : 1.0 - initial release
// ============================================================================
module tb_encoder_scan_ctrl;

    localparam int c_SCAN_PERIOD = 80;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] debounced;
    logic        host_req;
    logic [2:0]  host_idx;
    logic        host_ack;
    logic [7:0]  host_delta;
    logic        host_btn;
    logic        host_btn_chg;
    logic        host_err;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;
    int cyc_since_rst = 0;

    logic signed [31:0] rd_ack, rd_delta, rd_btn, rd_chg, rd_err;

    encoder_scan_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .debounced    (debounced),
        .host_req     (host_req),
        .host_idx     (host_idx),
        .host_ack     (host_ack),
        .host_delta   (host_delta),
        .host_btn     (host_btn),
        .host_btn_chg (host_btn_chg),
        .host_err     (host_err),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    // Clock edges since the last edge that sampled reset high
    always @(posedge clk) begin
        if (reset) cyc_since_rst <= 0;
        else       cyc_since_rst <= cyc_since_rst + 1;
    end

    task automatic chk(input string tag, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle read; captures the acknowledged data at the following negedge
    task automatic do_read(input logic [2:0] idx);
        @(negedge clk);
        host_req = 1'b1;
        host_idx = idx;
        @(negedge clk);
        host_req = 1'b0;
        host_idx = 3'd0;
        rd_ack   = 32'(host_ack);
        rd_delta = 32'($signed(host_delta));
        rd_btn   = 32'(host_btn);
        rd_chg   = 32'(host_btn_chg);
        rd_err   = 32'(host_err);
    endtask

    task automatic apply_reset(input logic [15:0] lvl);
        @(negedge clk);
        reset     = 1'b1;
        debounced = lvl;
        wait_clks(3);
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [1:0] rev_seq [4];
        logic [1:0] fwd_seq [4];
        logic [15:0] base;
        int guard;
        rev_seq[0] = 2'b00; rev_seq[1] = 2'b10; rev_seq[2] = 2'b11; rev_seq[3] = 2'b01;
        fwd_seq[0] = 2'b00; fwd_seq[1] = 2'b01; fwd_seq[2] = 2'b11; fwd_seq[3] = 2'b10;

        reset     = 1'b1;
        debounced = 16'hFFFF;
        host_req  = 1'b0;
        host_idx  = 3'd0;

        // 1. Reset state and first-visit initialisation with all levels high
        apply_reset(16'hFFFF);
        chk("rst_ack",   32'(host_ack), 0);
        chk("rst_irq",   32'(irq), 0);
        chk("rst_delta", 32'(host_delta), 0);
        wait_clks(2 * c_SCAN_PERIOD);
        chk("init_irq", 32'(irq), 0);
        for (int e = 0; e < 5; e++) begin
            do_read(3'(e));
            chk("init_delta", rd_delta, 0);
            chk("init_chg",   rd_chg,   0);
        end
        chk("init_btn", rd_btn, 1);

        // 2. Encoder 0 forward one full cycle = +4
        apply_reset(16'h0000);
        wait_clks(c_SCAN_PERIOD);
        for (int s = 1; s <= 4; s++) begin
            debounced = {14'd0, fwd_seq[s % 4]};
            wait_clks(c_SCAN_PERIOD);
        end
        chk("fwd_irq", 32'(irq), 1);
        do_read(3'd0);
        chk("fwd_ack",   rd_ack,   1);
        chk("fwd_delta", rd_delta, 4);
        chk("fwd_err",   rd_err,   0);
        do_read(3'd0);
        chk("fwd_reread", rd_delta, 0);
        wait_clks(2);
        chk("fwd_irq_clr", 32'(irq), 0);

        // 3. Encoder 2 reverse 200 steps saturates at -128
        for (int s = 1; s <= 200; s++) begin
            debounced = {8'd0, rev_seq[s % 4], 6'd0};
            wait_clks(c_SCAN_PERIOD);
        end
        do_read(3'd2);
        chk("sat_delta", rd_delta, -128);
        chk("sat_err",   rd_err,   0);

        // 4. Encoder 1 double-bit jump 00->11
        base      = 16'h0018;
        debounced = base;
        wait_clks(c_SCAN_PERIOD);
        do_read(3'd1);
        chk("jump_err",   rd_err,   1);
        chk("jump_delta", rd_delta, 0);
        do_read(3'd1);
        chk("jump_err_clr", rd_err, 0);

        // 5. Collision: read enc 3 on its scan-step edge while +1 is pending
        for (int s = 1; s <= 5; s++) begin
            debounced = base | (16'(fwd_seq[s % 4]) << 9);
            wait_clks(c_SCAN_PERIOD);
        end
        guard = 0;
        while (((cyc_since_rst + 1) % c_SCAN_PERIOD) != 64 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("coll_sync", 32'(guard < 200), 1);
        debounced = base | (16'(2'b11) << 9);
        host_req  = 1'b1;
        host_idx  = 3'd3;
        @(negedge clk);
        host_req = 1'b0;
        chk("coll_ack",   32'(host_ack), 1);
        chk("coll_delta", 32'($signed(host_delta)), 5);
        wait_clks(c_SCAN_PERIOD);
        do_read(3'd3);
        chk("coll_after", rd_delta, 1);
        chk("coll_err",   rd_err,   0);

        // 6. Encoder 4 button toggle; invalid index reads all zeros
        base      = base | 16'h0600;
        debounced = base | 16'h4000;
        wait_clks(c_SCAN_PERIOD);
        do_read(3'd6);
        chk("badidx_ack", rd_ack,   1);
        chk("badidx_chg", rd_chg,   0);
        chk("badidx_btn", rd_btn,   0);
        do_read(3'd4);
        chk("btn_chg",   rd_chg,   1);
        chk("btn_level", rd_btn,   1);
        chk("btn_delta", rd_delta, 0);
        wait_clks(2);
        chk("final_irq", 32'(irq), 0);
        chk("idle_ack",  32'(host_ack), 0);

        // Reset during a read drops the pending acknowledge
        @(negedge clk);
        host_req = 1'b1;
        host_idx = 3'd4;
        reset    = 1'b1;
        @(negedge clk);
        host_req = 1'b0;
        chk("rst_drop_ack", 32'(host_ack), 0);
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
